hex_display_scanner: RTL and testbench

- Upstream feeder for the seven-segment decoder.
- Accepts a multi-nibble value (PC, register or ALU result for the board demo) over a valid/ready handshake.
- Time-multiplexes the value one nibble at a time onto a single decoder, driving active-low digit selects with an anti-ghosting blank gap between digits.
- New values are applied only at frame boundaries, so the display never tears.

---
 rtl/hex_display_pkg.sv | 22 ++
 rtl/hex_display_phase_timer.sv | 52 +++++
 rtl/hex_display_scanner.sv | 247 ++++++++++++++++++++++++
 tb/tb_hex_display_scanner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// ----------------------------------------------------------------------------
// hex_display_pkg
// Shared types and constants for the multiplexed hex display scanner.
//   state_e   : scanner FSM states (IDLE, ON, GAP)
//   NIBBLE_W  : bits per displayed hex digit
//   DIGIT_OFF : all-ones digit select (every active-low enable released);
//               slice the low NUM_DIGITS bits for a given display width
// ----------------------------------------------------------------------------
package hex_display_pkg;

  localparam int NIBBLE_W = 4;

  // Widest supported display is 8 digits.
  localparam logic [7:0] DIGIT_OFF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/hex_display_phase_timer.sv
// ----------------------------------------------------------------------------
// hex_display_phase_timer
// Loadable down-counter that times the ON and GAP phases of the scanner.
// Loading value N-1 makes the phase last N cycles: tc_o is high in the
// final cycle of the phase (count == 0).
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (count -> 0)
//   load_i     in   load load_val_i on the next edge (takes priority)
//   load_val_i in   value to load
//   tc_o       out  current count is zero (last cycle of the phase)
//   tc_next_o  out  count will be zero after the next edge
// ----------------------------------------------------------------------------
module hex_display_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o,
  output logic             tc_next_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o      = (cnt_q == {CNT_W{1'b0}});
  assign tc_next_o = (cnt_d == {CNT_W{1'b0}});

endmodule

// File: rtl/hex_display_scanner.sv
// ----------------------------------------------------------------------------
// hex_display_scanner
// Time-multiplexes a NUM_DIGITS-nibble value onto one seven-segment decoder.
// Each digit is lit for CLK_DIV cycles, followed by GAP_CYCLES cycles with
// every digit off (anti-ghosting). Values arrive over valid/ready; outside
// IDLE they wait in a one-entry pending buffer and are copied into the
// displayed (shadow) register only at frame end, so a frame never tears.
//
// Parameters:
//   NUM_DIGITS  number of digits (1..8)
//   CLK_DIV     ON-phase length in cycles (>= 2)
//   GAP_CYCLES  blank-gap length in cycles (>= 1)
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   value_in    in   value to display, nibble 0 = rightmost digit
//   load_valid  in   value_in is valid
//   load_ready  out  block can accept a value
//   digit_out   out  nibble to the seven-segment decoder
//   digit_sel   out  active-low digit enables (one-hot-low or all ones)
//   blank_out   out  1 = decoder output must be forced off
//   frame_done  out  one-cycle pulse in the last gap cycle of the last digit
//
// Build option:
//   HEX_DISPLAY_LEAD_ZERO_BLANK_EN  when defined, digits above the most
//   significant nonzero nibble are blanked during ON (digit 0 always shown).
// ----------------------------------------------------------------------------
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int GAP_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
  input  logic                           load_valid,
  output logic                           load_ready,
  output logic [NIBBLE_W-1:0]            digit_out,
  output logic [NUM_DIGITS-1:0]          digit_sel,
  output logic                           blank_out,
  output logic                           frame_done
);

  localparam int VAL_W     = NIBBLE_W * NUM_DIGITS;
  localparam int MAX_PHASE = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PHASE + 1);
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // FSM and datapath state
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [VAL_W-1:0]      pending_q, pending_d;
  logic                  pending_full_q, pending_full_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [NIBBLE_W-1:0]   digit_out_q, digit_out_d;
  logic                  blank_q, blank_d;
  logic                  load_ready_q, load_ready_d;
  logic                  frame_done_q, frame_done_d;

  // Timer hookup and control strobes
  logic                  tmr_load_s;
  logic [CNT_W-1:0]      tmr_val_s;
  logic                  tmr_tc_s;
  logic                  tmr_tc_next_s;
  logic                  xfer_s;
  logic                  frame_end_s;

  assign xfer_s = load_valid && load_ready_q;

  hex_display_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .tc_o       (tmr_tc_s),
    .tc_next_o  (tmr_tc_next_s)
  );

`ifdef HEX_DISPLAY_LEAD_ZERO_BLANK_EN
  // Index of the most significant nonzero nibble; 0 for an all-zero value,
  // so a zero value still shows a single "0" on digit 0.
  function automatic logic [IDX_W-1:0] msd_index(input logic [VAL_W-1:0] v);
    msd_index = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[NIBBLE_W*i +: NIBBLE_W] != {NIBBLE_W{1'b0}}) begin
        msd_index = IDX_W'(i);
      end
    end
  endfunction
`endif

  // Scanner FSM: next state, digit index and phase-timer loads.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_load_s  = 1'b0;
    tmr_val_s   = {CNT_W{1'b0}};
    frame_end_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Keep the counter cleared while idle; a transfer starts digit 0.
        tmr_load_s = 1'b1;
        if (xfer_s) begin
          state_d   = ST_ON;
          idx_d     = {IDX_W{1'b0}};
          tmr_val_s = ON_LOAD;
        end else begin
          tmr_val_s = {CNT_W{1'b0}};
        end
      end
      ST_ON: begin
        if (tmr_tc_s) begin
          state_d    = ST_GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LOAD;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_GAP: begin
        if (tmr_tc_s) begin
          state_d    = ST_ON;
          tmr_load_s = 1'b1;
          tmr_val_s  = ON_LOAD;
          if (idx_q == LAST_IDX) begin
            idx_d       = {IDX_W{1'b0}};
            frame_end_s = 1'b1;
          end else begin
            idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Shadow/pending buffer. In IDLE a transfer goes straight to shadow;
  // otherwise it parks in pending until the frame end. A frame end with
  // pending full cannot coincide with a transfer (ready is low then).
  always_comb begin
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    if (state_q == ST_IDLE) begin
      if (xfer_s) begin
        shadow_d = value_in;
      end else begin
        shadow_d = shadow_q;
      end
    end else begin
      if (frame_end_s && pending_full_q) begin
        shadow_d       = pending_q;
        pending_full_d = 1'b0;
      end else begin
        shadow_d = shadow_q;
      end
      if (xfer_s) begin
        pending_d      = value_in;
        pending_full_d = 1'b1;
      end else begin
        pending_d = pending_q;
      end
    end
  end

  // Output values for the next cycle, derived from the next state so that
  // the registered outputs line up with the FSM state register.
  always_comb begin
    digit_sel_d = DIGIT_OFF[NUM_DIGITS-1:0];
    digit_out_d = digit_out_q;
    blank_d     = 1'b1;
    if (state_d == ST_ON) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_sel_d[i] = (idx_d != IDX_W'(i));
      end
      digit_out_d = shadow_d[NIBBLE_W*idx_d +: NIBBLE_W];
`ifdef HEX_DISPLAY_LEAD_ZERO_BLANK_EN
      blank_d = (idx_d > msd_index(shadow_d));
`else
      blank_d = 1'b0;
`endif
    end else begin
      // GAP/IDLE: all digits off, decoder forced dark, nibble holds.
      digit_sel_d = DIGIT_OFF[NUM_DIGITS-1:0];
      digit_out_d = digit_out_q;
      blank_d     = 1'b1;
    end
    // frame_done marks the final gap cycle of the last digit.
    frame_done_d = (state_d == ST_GAP) && (idx_d == LAST_IDX) && tmr_tc_next_s;
    if (state_d == ST_IDLE) begin
      load_ready_d = 1'b1;
    end else begin
      load_ready_d = !pending_full_d;
    end
  end

  // State, buffer and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= {IDX_W{1'b0}};
      shadow_q       <= {VAL_W{1'b0}};
      pending_q      <= {VAL_W{1'b0}};
      pending_full_q <= 1'b0;
      digit_sel_q    <= DIGIT_OFF[NUM_DIGITS-1:0];
      digit_out_q    <= {NIBBLE_W{1'b0}};
      blank_q        <= 1'b1;
      load_ready_q   <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      digit_sel_q    <= digit_sel_d;
      digit_out_q    <= digit_out_d;
      blank_q        <= blank_d;
      load_ready_q   <= load_ready_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign digit_sel  = digit_sel_q;
  assign digit_out  = digit_out_q;
  assign blank_out  = blank_q;
  assign load_ready = load_ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// ----------------------------------------------------------------------------
// tb_hex_display_scanner
// Directed bench for hex_display_scanner with NUM_DIGITS=4, CLK_DIV=4,
// GAP_CYCLES=2 (frame = 24 cycles: per digit 4 ON + 2 GAP).
// Expected display per frame position is computed from the frame layout.
// ----------------------------------------------------------------------------
module tb_hex_display_scanner;

  localparam int ND  = 4;
  localparam int CD  = 4;
  localparam int GC  = 2;
  localparam int PER = CD + GC;
  localparam int FRM = ND * PER;

  logic        clk;
  logic        reset_n;
  logic [15:0] value_in;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  digit_out;
  logic [3:0]  digit_sel;
  logic        blank_out;
  logic        frame_done;

  int checks_q;
  int errors_q;

  hex_display_scanner #(
    .NUM_DIGITS (ND),
    .CLK_DIV    (CD),
    .GAP_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value_in   (value_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digit_out  (digit_out),
    .digit_sel  (digit_sel),
    .blank_out  (blank_out),
    .frame_done (frame_done)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected blanking of an ON digit for the current build.
  function automatic logic exp_lz_blank(input logic [15:0] v, input int d);
    int msd;
    msd = 0;
`ifdef HEX_DISPLAY_LEAD_ZERO_BLANK_EN
    for (int i = 0; i < ND; i++) begin
      if (((v >> (4 * i)) & 16'h000F) != 16'h0000) msd = i;
    end
    return (d > msd);
`else
    msd = d;
    return 1'b0;
`endif
  endfunction

  // Check the display outputs at a given position of a frame showing v.
  task automatic check_frame(input int pos, input logic [15:0] v);
    int         d;
    logic       on;
    logic [3:0] sel;
    logic [3:0] nib;
    d   = pos / PER;
    on  = (pos % PER) < CD;
    sel = 4'hF;
    if (on) sel[d] = 1'b0;
    nib = 4'((v >> (4 * d)) & 16'h000F);
    check_eq($sformatf("sel@%0d", pos), {28'd0, digit_sel}, {28'd0, sel});
    check_eq($sformatf("out@%0d", pos), {28'd0, digit_out}, {28'd0, nib});
    check_eq($sformatf("blank@%0d", pos), {31'd0, blank_out},
             {31'd0, (on ? exp_lz_blank(v, d) : 1'b1)});
    check_eq($sformatf("fdone@%0d", pos), {31'd0, frame_done},
             {31'd0, (pos == FRM - 1)});
  endtask

  // Check positions from_pos..to_pos of a frame, stepping after each.
  task automatic run_frame(input logic [15:0] v, input int from_pos, input int to_pos,
                           input logic exp_ready);
    for (int p = from_pos; p <= to_pos; p++) begin
      check_frame(p, v);
      check_eq($sformatf("ready@%0d", p), {31'd0, load_ready}, {31'd0, exp_ready});
      step();
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_sel"},   {28'd0, digit_sel},  32'h0000_000F);
    check_eq({tag, "_out"},   {28'd0, digit_out},  32'h0000_0000);
    check_eq({tag, "_blank"}, {31'd0, blank_out},  32'h0000_0001);
    check_eq({tag, "_ready"}, {31'd0, load_ready}, 32'h0000_0001);
    check_eq({tag, "_fdone"}, {31'd0, frame_done}, 32'h0000_0000);
  endtask

  initial begin
    checks_q   = 0;
    errors_q   = 0;
    reset_n    = 1'b0;
    value_in   = 16'h0000;
    load_valid = 1'b0;
    #12;
    check_idle("rst");
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_idle("idle0");
    step();
    check_idle("idle1");

    // First value from IDLE: digit 0 lit the cycle after the transfer.
    value_in   = 16'h1A2F;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    run_frame(16'h1A2F, 0, FRM - 1, 1'b1);

    // Mid-frame load of 0BEE at position 7.
    run_frame(16'h1A2F, 0, 6, 1'b1);
    value_in   = 16'h0BEE;
    load_valid = 1'b1;
    check_frame(7, 16'h1A2F);
    step();
    // Second value held while pending is full: must not be taken yet.
    value_in = 16'h1234;
    run_frame(16'h1A2F, 8, FRM - 1, 1'b0);

    // New frame shows 0BEE, ready back; the held value transfers now.
    check_frame(0, 16'h0BEE);
    check_eq("ready_after_fd", {31'd0, load_ready}, 32'h0000_0001);
    step();
    load_valid = 1'b0;
    run_frame(16'h0BEE, 1, FRM - 1, 1'b0);

    // Frame showing 1234; park 0030 in pending, then reset in digit 2 ON.
    run_frame(16'h1234, 0, 4, 1'b1);
    value_in   = 16'h0030;
    load_valid = 1'b1;
    check_frame(5, 16'h1234);
    step();
    load_valid = 1'b0;
    run_frame(16'h1234, 6, 12, 1'b0);
    reset_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("post_rst%0d", i));
    end

    // 0030 from IDLE, then 0000 loaded at a frame start.
    value_in   = 16'h0030;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    run_frame(16'h0030, 0, FRM - 1, 1'b1);
    value_in   = 16'h0000;
    load_valid = 1'b1;
    check_frame(0, 16'h0030);
    step();
    load_valid = 1'b0;
    run_frame(16'h0030, 1, FRM - 1, 1'b0);
    run_frame(16'h0000, 0, FRM - 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
